corr_hex_framer: RTL
====================

CORR_HEX_FRAMER -- requirements
Module: corr_hex_framer

Interface
REQ-001 Parameter WINDOW, default 256: number of stb pulses per reporting window, legal range 2..65536.
REQ-002 Parameter HEX_UPPER, default 1: 1 selects 'A'-'F' hex digits, 0 selects 'a'-'f'.
REQ-003 clk  input  1  system clock; all logic is on posedge clk.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 stb  input  1  one-cycle sample strobe from the dispatcher.
REQ-006 hit3  input  1  correlator channel-3 hit, valid only when stb=1.
REQ-007 hit4  input  1  correlator channel-4 hit, valid only when stb=1.
REQ-008 tx_busy  input  1  UART transmitter busy, from acia_tx.
REQ-009 tx_start  output  1  one-cycle request to send tx_dat, to acia_tx.
REQ-010 tx_dat  output  8  byte to transmit, held stable from tx_start until tx_busy falls.
REQ-011 overrun  output  1  sticky flag: at least one window report was dropped.
REQ-012 frame_busy  output  1  high while a frame is being sent.

Function
REQ-013 Two 8-bit hit counters c3 and c4 shall increment on cycles where stb=1 and the matching hit is 1, and shall saturate at 0xFF.
REQ-014 A window counter shall increment on every stb; the stb that brings it to WINDOW shall close the window.
REQ-015 The closing stb's hits shall count in the closing window; on that cycle c3/c4 (including the closing hits, saturated) shall be copied to snapshot registers, and c3, c4 and the window counter shall be cleared to 0.
REQ-016 Each snapshot shall produce a 7-byte ASCII frame: hex(c3 high nibble), hex(c3 low nibble), 0x20, hex(c4 high nibble), hex(c4 low nibble), 0x0D, 0x0A.
REQ-017 The FSM states shall be IDLE, LOAD, START, WAIT_HI, WAIT_LO.
REQ-018 IDLE -> LOAD when a snapshot is pending; byte index = 0.
REQ-019 LOAD: register tx_dat for the current index; go to START.
REQ-020 START: when tx_busy=0, assert tx_start for exactly one cycle and go to WAIT_HI; otherwise remain in START.
REQ-021 WAIT_HI: when tx_busy=1, go to WAIT_LO.
REQ-022 WAIT_LO: when tx_busy=0, go to LOAD with index+1 if index<6; if index=6, go to IDLE.
REQ-023 frame_busy shall be 1 in every state except IDLE.
REQ-024 Latency from the window-closing stb to the first tx_start shall be 3 cycles when tx_busy=0.
REQ-025 Hit counting and window counting shall continue undisturbed while a frame is in flight.
REQ-026 A snapshot occurring while frame_busy=1 shall be discarded, the in-flight frame shall complete unchanged, and overrun shall be set.
REQ-027 A snapshot on the same cycle that the FSM returns to IDLE shall be accepted, not dropped.
REQ-028 The snapshot registers shall not change during a frame.

Reset
REQ-029 On rst=1, immediately and regardless of clk: tx_start=0, tx_dat=0x00, overrun=0, frame_busy=0, FSM=IDLE, all counters, snapshot and index = 0.
REQ-030 If reset is asserted mid-frame, the frame shall be abandoned and no resumption shall occur after release.
REQ-031 overrun shall be cleared only by rst.

Verification
REQ-032 WINDOW=4; 4 stb with hit3=1 and hit4=0; tx_busy modelled as 10 cycles after each tx_start -> bytes 30 34 20 30 30 0D 0A, with exactly 7 tx_start pulses.
REQ-033 300 stb with hit3=hit4=1 and WINDOW=512, then close the window -> frame "FF FF\r\n"; with HEX_UPPER=0, c3=0xAB gives 61 62.
REQ-034 WINDOW=4, tx_busy held 1 for 200 cycles, and two windows close -> first frame sent intact, second dropped, overrun=1.
REQ-035 tx_busy stuck 0 after a tx_start -> FSM waits in WAIT_HI and issues no further tx_start.
REQ-036 rst pulse during byte 3 -> outputs reset asynchronously; the next window yields a fresh, complete 7-byte frame.
REQ-037 Closing stb carries hit4=1 -> that hit appears in the reported c4, and the next window starts at c4=0.

Source files
------------

// File: rtl/corr_hex_framer.sv
// Counts channel-3/4 correlator hits over a window of stb pulses and reports each
// window as a 7-byte ASCII hex frame ("HH HH\r\n") through a byte-wide UART handshake.
module corr_hex_framer #(
  parameter int unsigned WINDOW    = 256,
  parameter bit          HEX_UPPER = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stb,
  input  logic       hit3,
  input  logic       hit4,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_dat,
  output logic       overrun,
  output logic       frame_busy
);

  localparam int unsigned WW = $clog2(WINDOW);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO} state_t;

  state_t        state;
  logic [7:0]    c3, c4, c3_nxt, c4_nxt;
  logic [7:0]    snap3, snap4;
  logic [WW-1:0] win_cnt;
  logic [2:0]    idx;
  logic          pending;
  logic          close, frame_done, accept;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return (HEX_UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  always_comb begin
    c3_nxt     = (stb && hit3 && c3 != 8'hFF) ? c3 + 8'd1 : c3;
    c4_nxt     = (stb && hit4 && c4 != 8'hFF) ? c4 + 8'd1 : c4;
    close      = stb && (win_cnt == WIN_LAST);
    frame_done = (state == WAIT_LO) && (idx == 3'd6) && !tx_busy;
    // A snapshot is taken only when no frame will be using the snapshot registers,
    // which includes the cycle on which the last byte completes.
    accept     = close && (((state == IDLE) && !pending) || frame_done);
  end

  always_comb begin
    case (idx)
      3'd0:    cur_byte = hex(snap3[7:4]);
      3'd1:    cur_byte = hex(snap3[3:0]);
      3'd2:    cur_byte = 8'h20;
      3'd3:    cur_byte = hex(snap4[7:4]);
      3'd4:    cur_byte = hex(snap4[3:0]);
      3'd5:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c3      <= '0;
      c4      <= '0;
      win_cnt <= '0;
      snap3   <= '0;
      snap4   <= '0;
      overrun <= 1'b0;
    end else begin
      if (close) begin
        c3      <= '0;
        c4      <= '0;
        win_cnt <= '0;
      end else begin
        c3 <= c3_nxt;
        c4 <= c4_nxt;
        if (stb) win_cnt <= win_cnt + WW'(1);
      end
      if (accept) begin
        snap3 <= c3_nxt;
        snap4 <= c4_nxt;
      end
      if (close && !accept) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      pending    <= 1'b0;
      tx_start   <= 1'b0;
      tx_dat     <= '0;
      frame_busy <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (accept) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (pending) begin
            pending    <= 1'b0;
            idx        <= '0;
            frame_busy <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          tx_dat <= cur_byte;
          state  <= START;
        end
        START: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (tx_busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (idx == 3'd6) begin
              frame_busy <= 1'b0;
              state      <= IDLE;
            end else begin
              idx   <= idx + 3'd1;
              state <= LOAD;
            end
          end
        end
        default: begin
          frame_busy <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
